fir_job_arbiter: RTL and testbench

FIR_JOB_ARBITER -- requirements
Module: fir_job_arbiter

---
 rtl/fir_job_arbiter.sv | 163 ++++++++++++++++
 tb/tb_fir_job_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_job_arbiter.sv
// Round-robin arbiter granting a single FIR engine to one of two job channels.
// Optional RUN watchdog enabled by defining FIR_JOB_ARBITER_TIMEOUT_EN.
module fir_job_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [11:0] req_wsp,
  input  logic [27:0] req_probek,
  input  logic [29:0] req_razy,
  output logic [1:0]  gnt,
  output logic [1:0]  job_done,
  output logic [1:0]  job_err,
  output logic [5:0]  f_ile_wsp,
  output logic [13:0] f_ile_probek,
  output logic [14:0] f_ile_razy,
  output logic        f_start,
  input  logic        f_done,
  output logic        fir_abort,
  output logic        busy,
  output logic        owner,
  output logic [1:0]  dbg_state
);

  // Handshake: a requester holds req and its config stable until it sees gnt
  // (or job_err) for its channel; req is only looked at while the state is IDLE.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_RUN    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  if (TIMEOUT_CYC == 0 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be in 1..65535");
  end

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_prio;
  logic        r_owner;
  logic [1:0]  r_job_err;
  logic [5:0]  r_ile_wsp;
  logic [13:0] r_ile_probek;
  logic [14:0] r_ile_razy;

  logic        w_sel;
  logic [5:0]  w_wsp;
  logic [13:0] w_probek;
  logic [14:0] w_razy;
  logic        w_legal;
  logic        w_take;
  logic        w_timeout;

  // Only contended requests consult the pointer; a lone request always wins.
  always_comb begin
    w_sel    = (req == 2'b11) ? r_prio : req[1];
    w_wsp    = w_sel ? req_wsp[11:6]     : req_wsp[5:0];
    w_probek = w_sel ? req_probek[27:14] : req_probek[13:0];
    w_razy   = w_sel ? req_razy[29:15]   : req_razy[14:0];
    w_legal  = (w_wsp != 6'd0) && (w_wsp <= 6'd32) &&
               (w_probek != 14'd0) && (w_razy != 15'd0);
    w_take   = (r_state == S_IDLE) && (req != 2'b00);
  end

`ifdef FIR_JOB_ARBITER_TIMEOUT_EN
  logic [15:0] r_cnt;
  logic        r_fir_abort;

  // f_done in the expiry cycle takes precedence over the abort.
  assign w_timeout = (r_state == S_RUN) && !f_done &&
                     ((r_cnt + 16'd1) == 16'(TIMEOUT_CYC));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= 16'd0;
      r_fir_abort <= 1'b0;
    end else begin
      r_fir_abort <= w_timeout;
      if (r_state == S_ISSUE) begin
        r_cnt <= 16'd0;
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign fir_abort = r_fir_abort;
`else
  assign w_timeout = 1'b0;
  assign fir_abort = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_take && w_legal) w_state_nxt = S_ISSUE;
      S_ISSUE:  w_state_nxt = S_RUN;
      S_RUN: begin
        if (f_done) begin
          w_state_nxt = S_FINISH;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio       <= 1'b0;
      r_owner      <= 1'b0;
      r_job_err    <= 2'b00;
      r_ile_wsp    <= 6'd0;
      r_ile_probek <= 14'd0;
      r_ile_razy   <= 15'd0;
    end else begin
      r_job_err <= 2'b00;
      if (w_take) begin
        r_prio <= ~w_sel;
        if (w_legal) begin
          r_owner      <= w_sel;
          r_ile_wsp    <= w_wsp;
          r_ile_probek <= w_probek;
          r_ile_razy   <= w_razy;
        end else begin
          r_job_err <= {w_sel, ~w_sel};
        end
      end
      if (r_state == S_FINISH) begin
        r_prio <= ~r_owner;
      end
      if (w_timeout) begin
        r_prio    <= ~r_owner;
        r_job_err <= {r_owner, ~r_owner};
      end
    end
  end

  assign gnt          = (r_state == S_ISSUE)  ? {r_owner, ~r_owner} : 2'b00;
  assign job_done     = (r_state == S_FINISH) ? {r_owner, ~r_owner} : 2'b00;
  assign job_err      = r_job_err;
  assign f_start      = (r_state == S_ISSUE);
  assign busy         = (r_state != S_IDLE);
  assign owner        = r_owner;
  assign f_ile_wsp    = r_ile_wsp;
  assign f_ile_probek = r_ile_probek;
  assign f_ile_razy   = r_ile_razy;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_fir_job_arbiter.sv
// Directed bench for fir_job_arbiter: single job, contention, illegal configs,
// mid-run reset and (with FIR_JOB_ARBITER_TIMEOUT_EN) the RUN watchdog.
module tb_fir_job_arbiter;

`ifdef FIR_JOB_ARBITER_TIMEOUT_EN
  localparam int unsigned TMO = 16;
`else
  localparam int unsigned TMO = 65535;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [11:0] req_wsp = 12'd0;
  logic [27:0] req_probek = 28'd0;
  logic [29:0] req_razy = 30'd0;
  logic        f_done = 1'b0;
  logic [1:0]  gnt, job_done, job_err, dbg_state;
  logic [5:0]  f_ile_wsp;
  logic [13:0] f_ile_probek;
  logic [14:0] f_ile_razy;
  logic        f_start, fir_abort, busy, owner;

  int total = 0;
  int bad   = 0;

  fir_job_arbiter #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wsp(req_wsp),
    .req_probek(req_probek), .req_razy(req_razy),
    .gnt(gnt), .job_done(job_done), .job_err(job_err),
    .f_ile_wsp(f_ile_wsp), .f_ile_probek(f_ile_probek), .f_ile_razy(f_ile_razy),
    .f_start(f_start), .f_done(f_done), .fir_abort(fir_abort),
    .busy(busy), .owner(owner), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int ch, input logic [5:0] w, input logic [13:0] p,
                         input logic [14:0] r);
    if (ch == 0) begin
      req_wsp[5:0] = w; req_probek[13:0] = p; req_razy[14:0] = r;
    end else begin
      req_wsp[11:6] = w; req_probek[27:14] = p; req_razy[29:15] = r;
    end
  endtask

  task automatic pulse_done();
    f_done = 1'b1;
    tick();
    f_done = 1'b0;
  endtask

  initial begin
    // Reset values while rst is held.
    tick(); tick();
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_done", job_done, 2'b00);
    chk("rst_err", job_err, 2'b00);
    chk("rst_start", f_start, 1'b0);
    chk("rst_abort", fir_abort, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_owner", owner, 1'b0);
    chk("rst_wsp", f_ile_wsp, 6'd0);
    rst = 1'b0;
    tick();

    // f_done in IDLE is ignored.
    f_done = 1'b1; tick(); f_done = 1'b0;
    chk("idle_fdone_busy", busy, 1'b0);
    chk("idle_fdone_done", job_done, 2'b00);

    // Single job on ch0.
    set_cfg(0, 6'd8, 14'd100, 15'd50);
    req = 2'b01;
    tick();
    chk("s_gnt", gnt, 2'b01);
    chk("s_start", f_start, 1'b1);
    chk("s_wsp", f_ile_wsp, 6'd8);
    chk("s_probek", f_ile_probek, 14'd100);
    chk("s_razy", f_ile_razy, 15'd50);
    chk("s_owner", owner, 1'b0);
    req = 2'b00;
    tick();
    chk("s_run_gnt", gnt, 2'b00);
    chk("s_run_start", f_start, 1'b0);
    chk("s_run_busy", busy, 1'b1);
    repeat (19) tick();
    chk("s_pre_done", job_done, 2'b00);
    pulse_done();
    chk("s_done", job_done, 2'b01);
    chk("s_done_gnt", gnt, 2'b00);
    tick();
    chk("s_idle_done", job_done, 2'b00);
    chk("s_idle_busy", busy, 1'b0);

    // Contention from reset: ch0 first, then ch1, then ch0 again.
    rst = 1'b1; tick(); rst = 1'b0;
    set_cfg(0, 6'd4, 14'd10, 15'd5);
    set_cfg(1, 6'd32, 14'd7, 15'd3);
    req = 2'b11;
    tick();
    chk("c1_gnt", gnt, 2'b01);
    chk("c1_wsp", f_ile_wsp, 6'd4);
    chk("c1_err", job_err, 2'b00);
    req = 2'b10;
    tick();
    pulse_done();
    chk("c1_done", job_done, 2'b01);
    tick();
    chk("c1_gap_gnt", gnt, 2'b00);
    tick();
    chk("c2_gnt", gnt, 2'b10);
    chk("c2_owner", owner, 1'b1);
    chk("c2_wsp", f_ile_wsp, 6'd32);
    chk("c2_probek", f_ile_probek, 14'd7);
    req = 2'b00;
    tick();
    pulse_done();
    chk("c2_done", job_done, 2'b10);
    tick();
    req = 2'b11;
    tick();
    chk("c3_gnt", gnt, 2'b01);
    req = 2'b00;
    tick();
    pulse_done();
    chk("c3_done", job_done, 2'b01);
    tick();

    // Illegal configs: rejected without grant, latched config untouched.
    set_cfg(1, 6'd0, 14'd7, 15'd3);
    req = 2'b10;
    tick();
    chk("i0_err", job_err, 2'b10);
    chk("i0_gnt", gnt, 2'b00);
    chk("i0_start", f_start, 1'b0);
    chk("i0_busy", busy, 1'b0);
    req = 2'b00;
    tick();
    chk("i0_err_clr", job_err, 2'b00);
    set_cfg(1, 6'd33, 14'd7, 15'd3);
    req = 2'b10;
    tick();
    chk("i33_err", job_err, 2'b10);
    chk("i33_gnt", gnt, 2'b00);
    chk("i33_start", f_start, 1'b0);
    chk("i33_wsp_kept", f_ile_wsp, 6'd4);
    req = 2'b00;
    tick();
    set_cfg(0, 6'd8, 14'd0, 15'd3);
    req = 2'b01;
    tick();
    chk("ip_err", job_err, 2'b01);
    chk("ip_gnt", gnt, 2'b00);
    req = 2'b00;
    tick();

    // Mid-run reset on a ch1 job.
    set_cfg(1, 6'd5, 14'd9, 15'd9);
    req = 2'b10;
    tick();
    chk("m_gnt", gnt, 2'b10);
    req = 2'b00;
    tick();
    repeat (4) tick();
    chk("m_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("m_rst_busy", busy, 1'b0);
    chk("m_rst_owner", owner, 1'b0);
    chk("m_rst_wsp", f_ile_wsp, 6'd0);
    chk("m_rst_razy", f_ile_razy, 15'd0);
    chk("m_rst_done", job_done, 2'b00);
    chk("m_rst_err", job_err, 2'b00);
    f_done = 1'b1;
    tick();
    rst = 1'b0;
    f_done = 1'b0;
    tick();
    chk("m_post_done", job_done, 2'b00);
    chk("m_post_abort", fir_abort, 1'b0);
    set_cfg(0, 6'd1, 14'd1, 15'd1);
    req = 2'b01;
    tick();
    chk("m_regnt", gnt, 2'b01);
    chk("m_regnt_wsp", f_ile_wsp, 6'd1);
    req = 2'b00;
    tick();
    pulse_done();
    chk("m_redone", job_done, 2'b01);
    tick();

    // Watchdog: 16 RUN cycles without f_done when enabled, otherwise none.
    set_cfg(0, 6'd2, 14'd2, 15'd2);
    req = 2'b01;
    tick();
    req = 2'b00;
    tick();
`ifdef FIR_JOB_ARBITER_TIMEOUT_EN
    repeat (15) tick();
    chk("t_pre_abort", fir_abort, 1'b0);
    chk("t_pre_busy", busy, 1'b1);
    tick();
    chk("t_abort", fir_abort, 1'b1);
    chk("t_err", job_err, 2'b01);
    chk("t_busy", busy, 1'b0);
    chk("t_done", job_done, 2'b00);
    tick();
    chk("t_abort_clr", fir_abort, 1'b0);
    chk("t_err_clr", job_err, 2'b00);
`else
    repeat (40) tick();
    chk("t_no_abort", fir_abort, 1'b0);
    chk("t_still_busy", busy, 1'b1);
    chk("t_no_err", job_err, 2'b00);
    pulse_done();
    chk("t_done", job_done, 2'b01);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
